// File: rtl/flasher_pkg.sv
// Shared constants and types for the light-flasher datapath: mode codes, rate
// exponent width, counter sizing and the light state encoding.
package flasher_pkg;

  localparam int unsigned MODE_W        = 3;
  localparam int unsigned RATE_W        = 2;
  localparam int unsigned MAX_SHIFT     = 3;
  localparam int unsigned TICKS_PER_SEC = 2 ** MAX_SHIFT;
  // Must hold the longest half-period, 2**(2*MAX_SHIFT) ticks.
  localparam int unsigned CNT_W         = 7;

  typedef logic [MODE_W-1:0] mode_t;

  // Master FSM state codes; 6 and 7 behave as OFF.
  localparam mode_t OFF1   = 3'd0;
  localparam mode_t ON     = 3'd1;
  localparam mode_t OFF2   = 3'd2;
  localparam mode_t FLASH1 = 3'd3;
  localparam mode_t OFF3   = 3'd4;
  localparam mode_t FLASH2 = 3'd5;

  typedef enum logic {
    LightOff,
    LightOn
  } light_e;

  function automatic logic is_flash_mode(mode_t m);
    return (m == FLASH1) || (m == FLASH2);
  endfunction

endpackage

// File: rtl/flash_timer_ctrl_if.sv
// Bus between master_fsm (master) and the flash timing controller (slave):
// mode code, shift pulses and base tick in; light drive, status and rates out.
interface flash_timer_ctrl_if;
  import flasher_pkg::*;

  logic              tick;
  mode_t             mode;
  logic              shift_left1;
  logic              shift_right1;
  logic              shift_left2;
  logic              shift_right2;
  logic              light;
  logic              flash_active;
  logic [RATE_W-1:0] rate1;
  logic [RATE_W-1:0] rate2;

  modport master (
    output tick, mode, shift_left1, shift_right1, shift_left2, shift_right2,
    input  light, flash_active, rate1, rate2
  );

  modport slave (
    input  tick, mode, shift_left1, shift_right1, shift_left2, shift_right2,
    output light, flash_active, rate1, rate2
  );

endinterface

// File: rtl/flash_rate_reg.sv
// Saturating up/down exponent register. Up and down together is a no-op;
// o_changed flags a step that will actually move the value on the next edge.
module flash_rate_reg import flasher_pkg::*; #(
  parameter int unsigned WIDTH   = RATE_W,
  parameter int unsigned MAX_VAL = MAX_SHIFT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_rate,
  output logic             o_changed
);

  logic [WIDTH-1:0] r_rate;
  logic [WIDTH-1:0] w_rate_nxt;
  logic             w_up;
  logic             w_down;

  assign w_up      = i_up & ~i_down & (r_rate != WIDTH'(MAX_VAL));
  assign w_down    = i_down & ~i_up & (r_rate != '0);
  assign o_changed = w_up | w_down;
  assign o_rate    = r_rate;

  // Next exponent: one step toward the requested end, clamped at 0 and MAX_VAL.
  always_comb begin
    w_rate_nxt = r_rate;
    if (w_up) begin
      w_rate_nxt = r_rate + WIDTH'(1);
    end else if (w_down) begin
      w_rate_nxt = r_rate - WIDTH'(1);
    end
  end

  // Exponent register; only reset clears it, mode changes never do.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rate <= '0;
    end else begin
      r_rate <= w_rate_nxt;
    end
  end

endmodule

// File: rtl/flash_timer_ctrl.sv
// Flash timing controller: holds the two flash-rate exponents, counts the 8 Hz
// base tick and drives the LED. Master FSM only sequences modes; all timing is here.
// Optional build macro FLASH_PHASE_RESET_EN: an effective rate change in the
// active flash mode restarts the on-phase with a cleared counter.
module flash_timer_ctrl #(
  parameter int unsigned MAX_SHIFT = flasher_pkg::MAX_SHIFT,
  parameter int unsigned CNT_W     = flasher_pkg::CNT_W
) (
  input logic               clk,
  input logic               reset_n,
  flash_timer_ctrl_if.slave bus
);
  import flasher_pkg::*;

  mode_t             w_mode;
  logic              w_is_f1;
  logic              w_is_f2;
  logic              w_flash;
  logic              w_entry;
  logic              w_phase_rst;
  logic [RATE_W-1:0] w_rate1;
  logic [RATE_W-1:0] w_rate2;
  logic              w_chg1;
  logic              w_chg2;
  logic [CNT_W-1:0]  w_base;
  logic [CNT_W-1:0]  w_period;
  logic [CNT_W-1:0]  w_last;
  logic [CNT_W-1:0]  w_cnt_nxt;
  light_e            w_light_nxt;

  logic [CNT_W-1:0]  r_cnt;
  mode_t             r_prev_mode;
  light_e            r_light;
  logic              r_flash_active;

  assign w_mode  = bus.mode;
  assign w_is_f1 = (w_mode == FLASH1);
  assign w_is_f2 = (w_mode == FLASH2);
  assign w_flash = is_flash_mode(w_mode);
  // Any change of mode into a flash mode (including FLASH1 <-> FLASH2) restarts it.
  assign w_entry = w_flash && (w_mode != r_prev_mode);

  // FLASH1: right pulse slows (exponent up). FLASH2: left pulse speeds (exponent up).
  flash_rate_reg #(
    .WIDTH   (RATE_W),
    .MAX_VAL (MAX_SHIFT)
  ) u_rate1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_up      (bus.shift_right1),
    .i_down    (bus.shift_left1),
    .o_rate    (w_rate1),
    .o_changed (w_chg1)
  );

  flash_rate_reg #(
    .WIDTH   (RATE_W),
    .MAX_VAL (MAX_SHIFT)
  ) u_rate2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_up      (bus.shift_left2),
    .i_down    (bus.shift_right2),
    .o_rate    (w_rate2),
    .o_changed (w_chg2)
  );

`ifdef FLASH_PHASE_RESET_EN
  assign w_phase_rst = (w_is_f1 & w_chg1) | (w_is_f2 & w_chg2);
`else
  logic w_unused_chg;
  assign w_unused_chg = w_chg1 ^ w_chg2;
  assign w_phase_rst  = 1'b0;
`endif

  assign w_base = CNT_W'(1) << MAX_SHIFT;

  // Half-period mux; uses the registered exponent so a same-cycle shift applies next cycle.
  always_comb begin
    w_period = w_base;
    if (w_is_f1) begin
      w_period = w_base << w_rate1;
    end else if (w_is_f2) begin
      w_period = w_base >> w_rate2;
    end
  end

  assign w_last = w_period - CNT_W'(1);

  // Light FSM next state; entry and phase reset take priority over a coincident tick.
  always_comb begin
    w_light_nxt = r_light;
    w_cnt_nxt   = r_cnt;
    if (w_mode == ON) begin
      w_light_nxt = LightOn;
      w_cnt_nxt   = '0;
    end else if (!w_flash) begin
      w_light_nxt = LightOff;
      w_cnt_nxt   = '0;
    end else if (w_entry || w_phase_rst) begin
      w_light_nxt = LightOn;
      w_cnt_nxt   = '0;
    end else if (bus.tick) begin
      // >= rather than == so a shortened period toggles at once instead of wrapping.
      if (r_cnt >= w_last) begin
        w_light_nxt = (r_light == LightOn) ? LightOff : LightOn;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // Light state, tick counter, previous mode and registered flash status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_light        <= LightOff;
      r_cnt          <= '0;
      r_prev_mode    <= OFF1;
      r_flash_active <= 1'b0;
    end else begin
      r_light        <= w_light_nxt;
      r_cnt          <= w_cnt_nxt;
      r_prev_mode    <= w_mode;
      r_flash_active <= w_flash;
    end
  end

  assign bus.light        = (r_light == LightOn);
  assign bus.flash_active = r_flash_active;
  assign bus.rate1        = w_rate1;
  assign bus.rate2        = w_rate2;

endmodule

// File: tb/tb_flash_timer_ctrl.sv
// Self-checking bench for flash_timer_ctrl: directed vectors, a behavioural
// model compared every cycle, and hand-computed literal expectations.
module tb_flash_timer_ctrl;
  import flasher_pkg::*;

`ifdef FLASH_PHASE_RESET_EN
  localparam bit PR = 1'b1;
`else
  localparam bit PR = 1'b0;
`endif

  // Shift pulse vectors, packed as {sl1, sr1, sl2, sr2}.
  localparam bit [3:0] NONE = 4'b0000;
  localparam bit [3:0] SL1  = 4'b1000;
  localparam bit [3:0] SR1  = 4'b0100;
  localparam bit [3:0] SL2  = 4'b0010;
  localparam bit [3:0] SR2  = 4'b0001;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  flash_timer_ctrl_if bus ();

  flash_timer_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    int e1;
    int e2;
    int cnt;   // ticks elapsed in the current half-period
    int prev;
    bit light;
    bit act;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, int mode, bit t, bit [3:0] sh);
    mstate_t n = s;
    bit ch1 = 1'b0;
    bit ch2 = 1'b0;
    bit flash;
    int p;
    if (sh[2] && !sh[3] && s.e1 < 3) begin n.e1 = s.e1 + 1; ch1 = 1'b1; end
    if (sh[3] && !sh[2] && s.e1 > 0) begin n.e1 = s.e1 - 1; ch1 = 1'b1; end
    if (sh[1] && !sh[0] && s.e2 < 3) begin n.e2 = s.e2 + 1; ch2 = 1'b1; end
    if (sh[0] && !sh[1] && s.e2 > 0) begin n.e2 = s.e2 - 1; ch2 = 1'b1; end
    flash  = (mode == 3) || (mode == 5);
    n.act  = flash;
    n.prev = mode;
    if (mode == 1) begin
      n.light = 1'b1; n.cnt = 0;
    end else if (!flash) begin
      n.light = 1'b0; n.cnt = 0;
    end else if (mode != s.prev) begin
      n.light = 1'b1; n.cnt = 0;
    end else if (PR && ((mode == 3 && ch1) || (mode == 5 && ch2))) begin
      n.light = 1'b1; n.cnt = 0;
    end else if (t) begin
      p = (mode == 3) ? (8 * (1 << s.e1)) : (8 / (1 << s.e2));
      n.cnt = s.cnt + 1;
      if (n.cnt >= p) begin
        n.light = !s.light;
        n.cnt   = 0;
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUT, from the inputs seen at that edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m <= '0;
    end else begin
      m <= model_next(m, int'(bus.mode), bus.tick,
                      {bus.shift_left1, bus.shift_right1, bus.shift_left2, bus.shift_right2});
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_light", int'(bus.light), int'(m.light));
      check("model_flash_active", int'(bus.flash_active), int'(m.act));
      check("model_rate1", int'(bus.rate1), m.e1);
      check("model_rate2", int'(bus.rate2), m.e2);
    end
  end

  task automatic cyc(input bit t, input bit [3:0] sh);
    bus.tick = t;
    {bus.shift_left1, bus.shift_right1, bus.shift_left2, bus.shift_right2} = sh;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    {bus.shift_left1, bus.shift_right1, bus.shift_left2, bus.shift_right2} = NONE;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, NONE);
  endtask

  initial begin
    bus.mode = OFF1;
    bus.tick = 1'b0;
    {bus.shift_left1, bus.shift_right1, bus.shift_left2, bus.shift_right2} = NONE;
    #2;
    reset_n = 1'b0;
    chk_en  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_light", int'(bus.light), 0);
    check("rst_active", int'(bus.flash_active), 0);
    check("rst_rate1", int'(bus.rate1), 0);
    check("rst_rate2", int'(bus.rate2), 0);
    reset_n = 1'b1;

    bus.mode = ON;
    cyc(1'b0, NONE);
    check("on_light", int'(bus.light), 1);
    check("on_active", int'(bus.flash_active), 0);

    // FLASH1, e1=0: 8 ticks on, 8 off.
    bus.mode = FLASH1;
    cyc(1'b0, NONE);
    check("f1_entry_light", int'(bus.light), 1);
    check("f1_active", int'(bus.flash_active), 1);
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b1, NONE);
      check("f1_e0_phase", int'(bus.light), ((k / 8) % 2 == 0) ? 1 : 0);
    end

    // Slow FLASH1 to saturation, then a conflicting pair.
    cyc(1'b0, SR1); check("sr1_a", int'(bus.rate1), 1);
    cyc(1'b0, SR1); check("sr1_b", int'(bus.rate1), 2);
    cyc(1'b0, SR1); check("sr1_c", int'(bus.rate1), 3);
    cyc(1'b0, SR1); check("sr1_sat", int'(bus.rate1), 3);
    cyc(1'b0, SL1 | SR1); check("sr1_both", int'(bus.rate1), 3);
    ticks(63);
    check("f1_p64_hold", int'(bus.light), int'(PR));
    ticks(1);
    check("f1_p64_toggle", int'(bus.light), int'(!PR));

    // Mid-count shortening: counter 20 of P=32, then P=16.
    cyc(1'b0, SL1);
    check("sl1_rate2", int'(bus.rate1), 2);
    check("sl1_light", int'(bus.light), 1);
    ticks(20);
    check("f1_cnt20_light", int'(bus.light), 1);
    cyc(1'b0, SL1);
    check("sl1_rate1", int'(bus.rate1), 1);
    check("sl1_mid_light", int'(bus.light), 1);
    ticks(1);
    check("f1_short_tick", int'(bus.light), int'(PR));
`ifdef FLASH_PHASE_RESET_EN
    ticks(14);
    check("f1_pr_hold", int'(bus.light), 1);
    ticks(1);
    check("f1_pr_toggle", int'(bus.light), 0);
`endif

    // Direct FLASH1 -> FLASH2 entry with a coincident tick: entry wins.
    bus.mode = FLASH2;
    cyc(1'b1, NONE);
    check("f2_entry_light", int'(bus.light), 1);
    check("f2_active", int'(bus.flash_active), 1);
    ticks(7);
    check("f2_e0_hold", int'(bus.light), 1);
    ticks(1);
    check("f2_e0_toggle", int'(bus.light), 0);

    // Speed FLASH2 to 1-tick half-period.
    cyc(1'b0, SL2); check("sl2_a", int'(bus.rate2), 1);
    cyc(1'b0, SL2); check("sl2_b", int'(bus.rate2), 2);
    cyc(1'b0, SL2); check("sl2_c", int'(bus.rate2), 3);
    check("sl2_light", int'(bus.light), int'(PR));
    ticks(1); check("f2_p1_t1", int'(bus.light), int'(!PR));
    ticks(1); check("f2_p1_t2", int'(bus.light), int'(PR));

    cyc(1'b0, SR2);
    check("sr2_rate", int'(bus.rate2), 2);
    ticks(1); check("f2_p2_t1", int'(bus.light), int'(PR));
    ticks(1); check("f2_p2_t2", int'(bus.light), int'(!PR));

    // Tick together with a shift: old period decides this tick (model checks).
    ticks(1);
    cyc(1'b1, SL2);
    check("tick_shift_rate", int'(bus.rate2), 3);
    cyc(1'b0, SR2);
    check("pre_rst_rate2", int'(bus.rate2), 2);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_light", int'(bus.light), 0);
    check("arst_rate2", int'(bus.rate2), 0);
    check("arst_active", int'(bus.flash_active), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1'b0, NONE);
    check("f2_reentry_light", int'(bus.light), 1);
    ticks(7);
    check("f2_reentry_hold", int'(bus.light), 1);
    ticks(1);
    check("f2_reentry_toggle", int'(bus.light), 0);

    // Codes 6/7 act as OFF; pulses still accepted, saturated ones ignored.
    bus.mode = 3'd6;
    cyc(1'b1, SR2);
    check("m6_light", int'(bus.light), 0);
    check("m6_active", int'(bus.flash_active), 0);
    check("m6_rate2_sat", int'(bus.rate2), 0);
    bus.mode = 3'd7;
    cyc(1'b0, SR1);
    check("m7_rate1", int'(bus.rate1), 1);
    check("m7_light", int'(bus.light), 0);
    bus.mode = ON;
    cyc(1'b0, NONE);
    check("on_again_light", int'(bus.light), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
